bcd_to_binary_seq: RTL

Sequential BCD-to-binary converter, the inverse of the clock's binary-to-BCD display path. It accepts a packed multi-digit BCD word, such as time-set digits entered on the 7-segment UI, and runs a reverse double-dabble over 4×DIGITS cycles, one bit per cycle. It returns the binary value with a one-cycle valid strobe. It sits between the BCD set/entry logic and the binary hour/minute/second counters.

---
 rtl/bcd_to_binary_seq_pkg.sv | 25 ++
 rtl/bcd_to_binary_seq_if.sv | 34 +++
 rtl/bcd_to_binary_seq_digit_adjust.sv | 21 ++
 rtl/bcd_to_binary_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bcd_to_binary_seq_pkg.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq_pkg
// Shared definitions for the sequential BCD-to-binary converter:
//   - state_t        : converter FSM states (IDLE / SHIFT / DONE)
//   - BCD_* constants: largest legal digit, correction threshold and amount
//   - cnt_width()    : width of the bit counter for a given digit count
// -----------------------------------------------------------------------------
package bcd_to_binary_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX     = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd8;
  localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

  // The counter is loaded with 4*digits, so it needs room for that value.
  function automatic int cnt_width(input int digits);
    return $clog2(4 * digits + 1);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq_if
// Request/result bundle of the BCD-to-binary converter.
//   i_start  : request, sampled only while the converter is idle
//   i_bcd    : packed BCD word, digit 0 in bits [3:0]
//   o_busy   : conversion in progress (SHIFT and DONE)
//   o_valid  : one-cycle strobe, o_binary/o_error updated in this cycle
//   o_binary : converted value, held until the next o_valid
//   o_error  : invalid digit or overflow on the last conversion
// master = requester (set/entry logic), slave = converter.
// -----------------------------------------------------------------------------
interface bcd_to_binary_seq_if #(
  parameter int DIGITS    = 2,
  parameter int BIN_WIDTH = 7
);

  logic                  i_start;
  logic [4*DIGITS-1:0]   i_bcd;
  logic                  o_busy;
  logic                  o_valid;
  logic [BIN_WIDTH-1:0]  o_binary;
  logic                  o_error;

  modport master (
    output i_start, i_bcd,
    input  o_busy, o_valid, o_binary, o_error
  );

  modport slave (
    input  i_start, i_bcd,
    output o_busy, o_valid, o_binary, o_error
  );

endinterface

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Per-nibble correction step of the reverse double-dabble: after the right
// shift, a nibble holding 8 or more has received a bit worth 8 from the digit
// above it, which should have been worth 5, so 3 is taken off.
//   i_nibble : shifted BCD nibble
//   o_nibble : corrected nibble
// Purely combinational.
// -----------------------------------------------------------------------------
module bcd_digit_adjust
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  // Only applied to values >= 8, so the subtraction cannot wrap.
  assign o_nibble = (i_nibble >= BCD_ADJ_THRESHOLD) ? (i_nibble - BCD_ADJ_VALUE)
                                                    : i_nibble;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per
// clock). A request accepted in IDLE spends 4*DIGITS cycles in SHIFT and one
// cycle in DONE, where the result is presented with a one-cycle o_valid.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset, priority over everything
//   bus     : bcd_to_binary_seq_if slave (i_start/i_bcd in, results out)
// Invalid digits or a value that does not fit BIN_WIDTH give o_binary=0 with
// o_error=1.
// -----------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int BIN_WIDTH = 7
) (
  input  logic               i_clk,
  input  logic               i_reset,
  bcd_to_binary_seq_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = cnt_width(DIGITS);

  state_t                r_state;
  logic [W-1:0]          r_bcd;
  logic [W-1:0]          r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_digit_err;
  logic                  r_busy;
  logic                  r_valid;
  logic [BIN_WIDTH-1:0]  r_binary;
  logic                  r_error;

  logic [W-1:0]          w_shift_bcd;
  logic [W-1:0]          w_shift_acc;
  logic [W-1:0]          w_adj_bcd;
  logic                  w_digit_err;
  logic                  w_overflow;

  // {bcd, acc} shifted right by one: the BCD LSB drops into the acc MSB.
  assign w_shift_bcd = {1'b0, r_bcd[W-1:1]};
  assign w_shift_acc = {r_bcd[0], r_acc[W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_nibble (w_shift_bcd[4*g +: 4]),
      .o_nibble (w_adj_bcd[4*g +: 4])
    );
  end

  // Digit legality is judged on the word as it is accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_digit_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.i_bcd[4*i +: 4] > BCD_DIGIT_MAX) w_digit_err = 1'b1;
    end
  end

  // Overflow is evaluated on the final shifted accumulator, i.e. the value the
  // last SHIFT edge is about to store.
  always_comb begin
    w_overflow = 1'b0;
    for (int i = BIN_WIDTH; i < W; i++) begin
      w_overflow = w_overflow | w_shift_acc[i];
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (i_reset) begin
      r_state     <= IDLE;
      r_bcd       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_digit_err <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_binary    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_bcd       <= bus.i_bcd;
            r_acc       <= '0;
            r_cnt       <= CW'(W);
            r_digit_err <= w_digit_err;
            r_busy      <= 1'b1;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_adj_bcd;
          r_acc <= w_shift_acc;
          r_cnt <= r_cnt - CW'(1);
          // Last bit: results are registered now so they appear in DONE.
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            if (r_digit_err || w_overflow) begin
              r_binary <= '0;
              r_error  <= 1'b1;
            end else begin
              r_binary <= BIN_WIDTH'(w_shift_acc);
              r_error  <= 1'b0;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_valid  = r_valid;
  assign bus.o_binary = r_binary;
  assign bus.o_error  = r_error;

endmodule
